input_frame_loader: RTL and testbench

INPUT_FRAME_LOADER -- requirements
Module: input_frame_loader

---
 rtl/snn_pkg.sv | 10 +
 rtl/frame_ram.sv | 25 ++
 rtl/input_frame_loader.sv | 95 +++++++++
 tb/tb_input_frame_loader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared types and parameter checks for the SNN input front end.
package snn_pkg;

    typedef enum logic {IDLE, UNPACK} state_t;

    function automatic bit pix_w_legal(input int w);
        return w == 1 || w == 2 || w == 4 || w == 8;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// frame_ram: simple dual-port RAM, one write port and one registered read port.
module frame_ram #(
    parameter int W  = 1,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  q
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else q <= mem[raddr];

endmodule

// File: rtl/input_frame_loader.sv
// input_frame_loader: unpacks pixel bytes into a ping-pong frame buffer
// read by the core one pixel at a time.
module input_frame_loader
    import snn_pkg::*;
#(
    parameter int PIX_W   = 1,
    parameter int NUM_PIX = 784
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       trigger,
    input  logic [7:0]                 data,
    input  logic                       clr,
    output logic                       byte_rdy,
    input  logic [$clog2(NUM_PIX)-1:0] rd_addr,
    output logic [PIX_W-1:0]           q,
    output logic                       frame_ready,
    input  logic                       frame_done,
    output logic                       overrun
);

    localparam int PPB = 8 / PIX_W;
    localparam int ADDR_W = $clog2(NUM_PIX);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIX - 1);

    if (!pix_w_legal(PIX_W)) begin : g_bad_pix_w
        $error("input_frame_loader: PIX_W must be 1, 2, 4 or 8");
    end

    state_t state, state_nx;
    logic [7:0] sr;
    logic [2:0] bcnt;
    logic [ADDR_W-1:0] pix_cnt;
    logic [1:0] full;
    logic wr_sel, rd_sel;
    logic accept, we, last_pix, byte_end, release_rd;

    always_comb begin
        byte_rdy = state == IDLE && !full[wr_sel];
        accept = trigger && byte_rdy && !clr;
        we = state == UNPACK && !clr;
        last_pix = we && pix_cnt == LAST;
        byte_end = bcnt == 3'(PPB - 1) || pix_cnt == LAST;
        release_rd = frame_done && full[rd_sel];
        state_nx = state;
        if (clr) state_nx = IDLE;
        else if (accept) state_nx = UNPACK;
        else if (state == UNPACK && byte_end) state_nx = IDLE;
    end

    assign frame_ready = full[rd_sel];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
            bcnt <= '0;
            pix_cnt <= '0;
            full <= 2'b00;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (trigger && !byte_rdy && !clr) overrun <= 1'b1;
            if (accept) begin
                sr <= data;
                bcnt <= '0;
            end else if (we) begin
                sr <= sr << PIX_W;
                bcnt <= bcnt + 3'd1;
            end
            if (clr) pix_cnt <= '0;
            else if (we) pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
            if (last_pix) wr_sel <= !wr_sel;
            if (release_rd) rd_sel <= !rd_sel;
            // Completion and release touch different buffers, so both apply.
            full <= (full | (last_pix ? 2'b01 << wr_sel : 2'b00))
                    & ~(release_rd ? 2'b01 << rd_sel : 2'b00);
        end
    end

    frame_ram #(.W(PIX_W), .AW(ADDR_W + 1)) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .waddr({wr_sel, pix_cnt}),
        .wdata(sr[7 -: PIX_W]),
        .raddr({rd_sel, rd_addr}),
        .q    (q)
    );

endmodule

// File: tb/tb_input_frame_loader.sv
// tb_input_frame_loader: directed bench for the default loader and a
// PIX_W=4, NUM_PIX=3 instance; pixel reads go through a scoreboard.
module tb_input_frame_loader;

    localparam int AW = 10;

    logic clk = 0, rst_n = 0;
    logic trigger = 0, clr = 0, frame_done = 0;
    logic [7:0] data = 0;
    logic [AW-1:0] rd_addr = 0;
    logic byte_rdy, frame_ready, overrun;
    logic [0:0] q;

    logic trigger2 = 0, clr2 = 0, frame_done2 = 0;
    logic [7:0] data2 = 0;
    logic [1:0] rd_addr2 = 0;
    logic byte_rdy2, frame_ready2, overrun2;
    logic [3:0] q2;

    int total = 0, bad = 0;
    logic rd_req = 0, rd_req2 = 0;
    int exp_q[$], exp_q2[$];
    logic [7:0] pat;

    always #10 clk = ~clk;

    input_frame_loader u_dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .data(data), .clr(clr),
        .byte_rdy(byte_rdy), .rd_addr(rd_addr), .q(q), .frame_ready(frame_ready),
        .frame_done(frame_done), .overrun(overrun)
    );

    input_frame_loader #(.PIX_W(4), .NUM_PIX(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .trigger(trigger2), .data(data2), .clr(clr2),
        .byte_rdy(byte_rdy2), .rd_addr(rd_addr2), .q(q2), .frame_ready(frame_ready2),
        .frame_done(frame_done2), .overrun(overrun2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        while (!byte_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_wait", 32'(n < 50), 1);
        trigger = 1;
        data = b;
        @(negedge clk);
        trigger = 0;
    endtask

    task automatic rd(input int a, input int e);
        rd_addr = AW'(a);
        rd_req = 1;
        exp_q.push_back(e);
        @(negedge clk);
        rd_req = 0;
    endtask

    task automatic rd2(input int a, input int e);
        rd_addr2 = 2'(a);
        rd_req2 = 1;
        exp_q2.push_back(e);
        @(negedge clk);
        rd_req2 = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_byte_rdy", 32'(byte_rdy), 1);
        chk("rst_frame_ready", 32'(frame_ready), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_q", 32'(q), 0);
        rst_n = 1;
        @(negedge clk);
    endtask

    // Monitor: a read request is answered on q one cycle later.
    always begin : mon
        logic r1, r2;
        int e;
        @(posedge clk);
        r1 = rd_req;
        r2 = rd_req2;
        #2;
        if (r1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL q_underflow: got %0h want none", q);
            end else begin
                e = exp_q.pop_front();
                if (q !== 1'(e)) begin
                    bad++;
                    $display("FAIL q addr=%0d: got %0h want %0h", rd_addr, q, e);
                end
            end
        end
        if (r2) begin
            total++;
            if (exp_q2.size() == 0) begin
                bad++;
                $display("FAIL q2_underflow: got %0h want none", q2);
            end else begin
                e = exp_q2.pop_front();
                if (q2 !== 4'(e)) begin
                    bad++;
                    $display("FAIL q2 addr=%0d: got %0h want %0h", rd_addr2, q2, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk("rst_byte_rdy2", 32'(byte_rdy2), 1);
        chk("rst_frame_ready2", 32'(frame_ready2), 0);

        // Nibble instance: two pixels, then one pixel that ends the frame.
        trigger2 = 1; data2 = 8'h3C;
        @(negedge clk); trigger2 = 0;
        @(negedge clk); chk("p4_unpack_busy", 32'(byte_rdy2), 0);
        @(negedge clk); chk("p4_idle", 32'(byte_rdy2), 1);
        trigger2 = 1; data2 = 8'h7F;
        @(negedge clk); trigger2 = 0;
        chk("p4_unpack2", 32'(byte_rdy2), 0);
        @(negedge clk);
        chk("p4_one_cycle", 32'(byte_rdy2), 1);
        chk("p4_frame_ready", 32'(frame_ready2), 1);
        chk("p4_overrun", 32'(overrun2), 0);
        rd2(0, 3); rd2(1, 12); rd2(2, 7);

        // Full frame of 0xA5.
        for (int i = 0; i < 97; i++) send(8'hA5);
        chk("fr_early", 32'(frame_ready), 0);
        send(8'hA5);
        repeat (7) @(negedge clk);
        chk("fr_before_last", 32'(frame_ready), 0);
        @(negedge clk);
        chk("fr_rise", 32'(frame_ready), 1);
        chk("buf1_free", 32'(byte_rdy), 1);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) rd(i, int'(pat[7-i]));
        rd(783, 1);

        // Second frame without release: both buffers full, overrun.
        for (int i = 0; i < 98; i++) send(8'h0F);
        repeat (8) @(negedge clk);
        chk("both_full", 32'(byte_rdy), 0);
        trigger = 1; data = 8'hFF;
        @(negedge clk); trigger = 0;
        chk("overrun_full", 32'(overrun), 1);
        for (int i = 0; i < 8; i++) rd(i, int'(pat[7-i]));
        frame_done = 1;
        @(negedge clk); frame_done = 0;
        chk("release_rdy", 32'(byte_rdy), 1);
        chk("second_ready", 32'(frame_ready), 1);
        pat = 8'h0F;
        for (int i = 0; i < 8; i++) rd(i, int'(pat[7-i]));
        frame_done = 1;
        @(negedge clk); frame_done = 0;
        chk("all_released", 32'(frame_ready), 0);
        chk("overrun_sticky", 32'(overrun), 1);

        // Trigger on the second UNPACK cycle is dropped.
        do_reset();
        trigger = 1; data = 8'hF0;
        @(negedge clk); trigger = 0;
        @(negedge clk); trigger = 1; data = 8'hFF;
        @(negedge clk); trigger = 0;
        repeat (8) @(negedge clk);
        chk("overrun_unpack", 32'(overrun), 1);
        for (int i = 0; i < 96; i++) send(8'h00);
        repeat (10) @(negedge clk);
        chk("drop_no_advance", 32'(frame_ready), 0);
        send(8'h00);
        repeat (10) @(negedge clk);
        chk("drop_frame", 32'(frame_ready), 1);
        pat = 8'hF0;
        for (int i = 0; i < 8; i++) rd(i, int'(pat[7-i]));
        rd(8, 0);

        // clr aborts a partial frame mid-byte.
        do_reset();
        for (int i = 0; i < 50; i++) send(8'h00);
        trigger = 1; data = 8'h00;
        @(negedge clk); trigger = 0;
        @(negedge clk); clr = 1;
        @(negedge clk); clr = 0;
        chk("clr_idle", 32'(byte_rdy), 1);
        chk("clr_no_frame", 32'(frame_ready), 0);
        for (int i = 0; i < 98; i++) send(8'hFF);
        repeat (10) @(negedge clk);
        chk("clr_frame", 32'(frame_ready), 1);
        for (int i = 0; i < 784; i++) rd(i, 1);

        // Asynchronous reset in the middle of byte 10.
        for (int i = 0; i < 9; i++) send(8'h00);
        send(8'h00);
        trigger = 1; data = 8'hFF;
        @(negedge clk); trigger = 0;
        chk("pre_rst_overrun", 32'(overrun), 1);
        #3 rst_n = 0;
        #1;
        chk("arst_byte_rdy", 32'(byte_rdy), 1);
        chk("arst_frame_ready", 32'(frame_ready), 0);
        chk("arst_overrun", 32'(overrun), 0);
        chk("arst_q", 32'(q), 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        for (int i = 0; i < 98; i++) send(8'h5A);
        repeat (10) @(negedge clk);
        chk("post_rst_frame", 32'(frame_ready), 1);
        chk("post_rst_rdy", 32'(byte_rdy), 1);
        pat = 8'h5A;
        for (int i = 0; i < 8; i++) rd(i, int'(pat[7-i]));

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size() + exp_q2.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
